// File: rtl/game_referee_if.sv
// Signal bundle between the pong referee and the rest of the game:
// ball/paddle positions and frame timing in, bounce pulses, scores and
// serve/match status out. The referee uses the slave modport.
interface game_referee_if;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] p1_y;
  logic [8:0] p2_y;
  logic       h_col;
  logic       v_col;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       ball_hold;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  modport master (
    output frame_tick, start, ball_x, ball_y, p1_y, p2_y,
    input  h_col, v_col, p1_score, p2_score, ball_hold, serve_dir,
           game_over, winner
  );

  modport slave (
    input  frame_tick, start, ball_x, ball_y, p1_y, p2_y,
    output h_col, v_col, p1_score, p2_score, ball_hold, serve_dir,
           game_over, winner
  );
endinterface

// File: rtl/game_referee.sv
// Pong referee: serve timing, paddle/wall bounce detection, miss scoring
// and match end. Bounce pulses are registered, so they appear in the clk
// after the frame_tick that evaluated the ball.
// Optional feature: define GAME_REFEREE_PAUSE_EN to add a level 'pause'
// input that freezes serve counting and play while high.
module game_referee #(
  parameter int PADDLE_H     = 75,
  parameter int PADDLE_W     = 5,
  parameter int BALL_R       = 8,
  parameter int P1_X         = 30,
  parameter int P2_X         = 600,
  parameter int MISS_L       = 20,
  parameter int MISS_R       = 620,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic          clk,
  input  logic          reset,
`ifdef GAME_REFEREE_PAUSE_EN
  input  logic          pause,
`endif
  game_referee_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  // Serve counter runs 0..SERVE_FRAMES-1
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  // All geometry is compared in 11 bits with only additions on the ball
  // side, so nothing can underflow or wrap.
  localparam logic [10:0] P1_X_LO  = 11'(P1_X);
  localparam logic [10:0] P1_X_HI  = 11'(P1_X + PADDLE_W + BALL_R);
  localparam logic [10:0] P2_X_LO  = 11'(P2_X);
  localparam logic [10:0] P2_X_HI  = 11'(P2_X + PADDLE_W);
  localparam logic [10:0] BR       = 11'(BALL_R);
  localparam logic [10:0] Y_SPAN   = 11'(PADDLE_H + BALL_R);
  localparam logic [10:0] V_BOT    = 11'(480 - BALL_R);
  localparam logic [10:0] MISS_L_C = 11'(MISS_L);
  localparam logic [10:0] MISS_R_C = 11'(MISS_R);
  localparam logic [3:0]  WIN_C    = 4'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [3:0]       p1_score_q, p1_score_d;
  logic [3:0]       p2_score_q, p2_score_d;
  logic             h_col_q, h_col_d;
  logic             v_col_q, v_col_d;
  logic             serve_dir_q, serve_dir_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             start_prev_q, start_prev_d;
  logic             scorer_q, scorer_d;   // 1 = P2 won the pending point

  logic        pause_i;
  logic        paused;
  logic        tick;
  logic        start_edge;
  logic [10:0] bx, by, p1y, p2y;
  logic        p1_hit, p2_hit, wall_hit, miss_l, miss_r;

`ifdef GAME_REFEREE_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // Pause only matters while the ball is being served or in play
  assign paused     = pause_i && ((state_q == PLAY) || (state_q == SERVE));
  assign tick       = bus.frame_tick && !paused;
  assign start_edge = bus.start && !start_prev_q;

  assign bx  = {1'b0, bus.ball_x};
  assign by  = {2'b0, bus.ball_y};
  assign p1y = {2'b0, bus.p1_y};
  assign p2y = {2'b0, bus.p2_y};

  assign p1_hit   = (bx >= P1_X_LO) && (bx <= P1_X_HI) &&
                    (by + BR >= p1y) && (by <= p1y + Y_SPAN);
  assign p2_hit   = (bx + BR >= P2_X_LO) && (bx <= P2_X_HI) &&
                    (by + BR >= p2y) && (by <= p2y + Y_SPAN);
  assign wall_hit = (by <= BR) || (by >= V_BOT);
  assign miss_l   = (bx < MISS_L_C);
  assign miss_r   = (bx > MISS_R_C);

  // Next-state, scoring and bounce-pulse logic
  always_comb begin
    state_d      = state_q;
    p1_score_d   = p1_score_q;
    p2_score_d   = p2_score_q;
    h_col_d      = 1'b0;
    v_col_d      = 1'b0;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    serve_cnt_d  = serve_cnt_q;
    start_prev_d = bus.start;
    scorer_d     = scorer_q;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          p1_score_d  = 4'd0;
          p2_score_d  = 4'd0;
          serve_cnt_d = '0;
          state_d     = SERVE;
        end
      end

      SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (tick) begin
          // A miss wins over any bounce on the same frame
          if (miss_l) begin
            scorer_d = 1'b1;
            state_d  = POINT;
          end else if (miss_r) begin
            scorer_d = 1'b0;
            state_d  = POINT;
          end else begin
            h_col_d = p1_hit || p2_hit;
            v_col_d = wall_hit;
          end
        end
      end

      POINT: begin
        serve_cnt_d = '0;
        if (scorer_q) begin
          if (p2_score_q < WIN_C) p2_score_d = p2_score_q + 4'd1;
          if (p2_score_d == WIN_C) begin
            winner_d = 1'b1;
            state_d  = GAME_OVER;
          end else begin
            serve_dir_d = 1'b0;   // P1 conceded: serve toward the left
            state_d     = SERVE;
          end
        end else begin
          if (p1_score_q < WIN_C) p1_score_d = p1_score_q + 4'd1;
          if (p1_score_d == WIN_C) begin
            winner_d = 1'b0;
            state_d  = GAME_OVER;
          end else begin
            serve_dir_d = 1'b1;   // P2 conceded: serve toward the right
            state_d     = SERVE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      p1_score_q   <= 4'd0;
      p2_score_q   <= 4'd0;
      h_col_q      <= 1'b0;
      v_col_q      <= 1'b0;
      serve_dir_q  <= 1'b0;
      winner_q     <= 1'b0;
      serve_cnt_q  <= '0;
      start_prev_q <= 1'b0;
      scorer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      h_col_q      <= h_col_d;
      v_col_q      <= v_col_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      serve_cnt_q  <= serve_cnt_d;
      start_prev_q <= start_prev_d;
      scorer_q     <= scorer_d;
    end
  end

  assign bus.h_col     = h_col_q;
  assign bus.v_col     = v_col_q;
  assign bus.p1_score  = p1_score_q;
  assign bus.p2_score  = p2_score_q;
  assign bus.ball_hold = (state_q != PLAY) || paused;
  assign bus.serve_dir = serve_dir_q;
  assign bus.game_over = (state_q == GAME_OVER);
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: table of in-play vectors plus hand-written
// serve, miss, match-end and reset-during-point sequences. Expected
// outputs come from a small scoring model and are queued per frame.
module tb_game_referee;
  localparam int WIN = 9;

  typedef struct {
    logic [9:0] bx;
    logic [8:0] by;
    logic [8:0] p1y;
    logic [8:0] p2y;
    logic       h;
    logic       v;
  } vec_t;

  typedef struct {
    logic       h;
    logic       v;
    logic [3:0] p1s;
    logic [3:0] p2s;
    logic       hold;
    logic       dir;
    logic       go;
    logic       win;
  } exp_t;

  logic clk;
  logic reset;
`ifdef GAME_REFEREE_PAUSE_EN
  logic pause;
`endif

  game_referee_if bus();

  game_referee dut (
    .clk   (clk),
    .reset (reset),
`ifdef GAME_REFEREE_PAUSE_EN
    .pause (pause),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t tbl[18];

  // Scoring model state
  int   m_p1, m_p2;
  logic m_dir, m_go, m_win;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_dir = 1'b0; m_go = 1'b0; m_win = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk) bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // One frame in PLAY: model the outcome, queue it, drive the tick and
  // compare the bounce pulse, then the settled state one clk later.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    e.h = v.h; e.v = v.v; e.hold = 1'b0;
    if (v.bx < 10'd20) begin
      if (m_p2 < WIN) m_p2++;
      if (m_p2 == WIN) begin m_go = 1'b1; m_win = 1'b1; end
      else m_dir = 1'b0;
      e.h = 1'b0; e.v = 1'b0; e.hold = 1'b1;
    end else if (v.bx > 10'd620) begin
      if (m_p1 < WIN) m_p1++;
      if (m_p1 == WIN) begin m_go = 1'b1; m_win = 1'b0; end
      else m_dir = 1'b1;
      e.h = 1'b0; e.v = 1'b0; e.hold = 1'b1;
    end
    e.p1s = 4'(m_p1); e.p2s = 4'(m_p2);
    e.dir = m_dir; e.go = m_go; e.win = m_win;
    sb.push_back(e);

    @(negedge clk);
    bus.ball_x = v.bx; bus.ball_y = v.by; bus.p1_y = v.p1y; bus.p2_y = v.p2y;
    bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    got = sb.pop_front();
    chk({tag, ".h_col"}, int'(bus.h_col), int'(got.h));
    chk({tag, ".v_col"}, int'(bus.v_col), int'(got.v));
    @(negedge clk);
    chk({tag, ".h_col_end"}, int'(bus.h_col), 0);
    chk({tag, ".v_col_end"}, int'(bus.v_col), 0);
    chk({tag, ".p1_score"}, int'(bus.p1_score), int'(got.p1s));
    chk({tag, ".p2_score"}, int'(bus.p2_score), int'(got.p2s));
    chk({tag, ".ball_hold"}, int'(bus.ball_hold), int'(got.hold));
    chk({tag, ".serve_dir"}, int'(bus.serve_dir), int'(got.dir));
    chk({tag, ".game_over"}, int'(bus.game_over), int'(got.go));
    if (got.go) chk({tag, ".winner"}, int'(bus.winner), int'(got.win));
    $display("%s: bx=%0d by=%0d p1y=%0d p2y=%0d h=%0d v=%0d score=%0d:%0d hold=%0d",
             tag, v.bx, v.by, v.p1y, v.p2y, bus.h_col, bus.v_col,
             bus.p1_score, bus.p2_score, bus.ball_hold);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, ".p1_score"}, int'(bus.p1_score), 0);
    chk({tag, ".p2_score"}, int'(bus.p2_score), 0);
    chk({tag, ".ball_hold"}, int'(bus.ball_hold), 1);
    chk({tag, ".game_over"}, int'(bus.game_over), 0);
    chk({tag, ".serve_dir"}, int'(bus.serve_dir), 0);
    chk({tag, ".winner"}, int'(bus.winner), 0);
    chk({tag, ".h_col"}, int'(bus.h_col), 0);
    chk({tag, ".v_col"}, int'(bus.v_col), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             bx   by   p1y  p2y  h     v
    tbl[0]  = '{10'd36,  9'd100, 9'd50,  9'd300, 1'b1, 1'b0};
    tbl[1]  = '{10'd300, 9'd5,   9'd50,  9'd300, 1'b0, 1'b1};
    tbl[2]  = '{10'd36,  9'd472, 9'd420, 9'd300, 1'b1, 1'b1};
    tbl[3]  = '{10'd595, 9'd200, 9'd50,  9'd180, 1'b1, 1'b0};
    tbl[4]  = '{10'd320, 9'd240, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[5]  = '{10'd43,  9'd100, 9'd50,  9'd300, 1'b1, 1'b0};
    tbl[6]  = '{10'd44,  9'd100, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[7]  = '{10'd36,  9'd100, 9'd108, 9'd300, 1'b1, 1'b0};
    tbl[8]  = '{10'd36,  9'd100, 9'd109, 9'd300, 1'b0, 1'b0};
    tbl[9]  = '{10'd36,  9'd133, 9'd50,  9'd300, 1'b1, 1'b0};
    tbl[10] = '{10'd36,  9'd134, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[11] = '{10'd300, 9'd8,   9'd50,  9'd300, 1'b0, 1'b1};
    tbl[12] = '{10'd300, 9'd9,   9'd50,  9'd300, 1'b0, 1'b0};
    tbl[13] = '{10'd300, 9'd471, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[14] = '{10'd20,  9'd240, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[15] = '{10'd620, 9'd240, 9'd50,  9'd300, 1'b0, 1'b0};
    tbl[16] = '{10'd605, 9'd240, 9'd50,  9'd230, 1'b1, 1'b0};
    tbl[17] = '{10'd29,  9'd100, 9'd50,  9'd300, 1'b0, 1'b0};

    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.ball_x = 10'd320; bus.ball_y = 9'd240;
    bus.p1_y = 9'd200; bus.p2_y = 9'd200;
`ifdef GAME_REFEREE_PAUSE_EN
    pause = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_state("reset");

    // Serve: ball held through 59 ticks, released on the 60th
    press_start();
    chk("serve.hold_after_start", int'(bus.ball_hold), 1);
    ticks(59);
    chk("serve.hold_tick59", int'(bus.ball_hold), 1);
    ticks(1);
    chk("serve.hold_tick60", int'(bus.ball_hold), 0);
    $display("serve: released after 60 ticks hold=%0d", bus.ball_hold);

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Start edge during play is ignored
    press_start();
    chk("play_start.hold", int'(bus.ball_hold), 0);
    chk("play_start.p1_score", int'(bus.p1_score), 0);

    // Right miss held for 3 frames scores once for P1
    apply('{10'd625, 9'd240, 9'd50, 9'd300, 1'b0, 1'b0}, "miss_r");
    ticks(2);
    chk("miss_r_held.p1_score", int'(bus.p1_score), 1);
    chk("miss_r_held.p2_score", int'(bus.p2_score), 0);
    ticks(58);
    chk("miss_r.replay_hold", int'(bus.ball_hold), 0);

    // P2 scores up to the win
    for (int k = 0; k < WIN; k++) begin
      apply('{10'd10, 9'd240, 9'd50, 9'd300, 1'b0, 1'b0}, $sformatf("miss_l%0d", k));
      if (k < WIN - 1) begin
        ticks(60);
        chk($sformatf("miss_l%0d.replay_hold", k), int'(bus.ball_hold), 0);
      end
    end
    ticks(3);
    chk("gameover.stays", int'(bus.game_over), 1);
    chk("gameover.p2_score", int'(bus.p2_score), WIN);
    chk("gameover.winner", int'(bus.winner), 1);

    // New match from GAME_OVER
    press_start();
    m_p1 = 0; m_p2 = 0; m_go = 1'b0;
    chk("restart.p1_score", int'(bus.p1_score), 0);
    chk("restart.p2_score", int'(bus.p2_score), 0);
    chk("restart.game_over", int'(bus.game_over), 0);
    chk("restart.hold", int'(bus.ball_hold), 1);
    ticks(60);
    chk("restart.play_hold", int'(bus.ball_hold), 0);

    // Reset landing on the POINT cycle wipes everything
    apply('{10'd625, 9'd240, 9'd50, 9'd300, 1'b0, 1'b0}, "pre_reset");
    ticks(60);
    @(negedge clk);
    bus.ball_x = 10'd10; bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_reset();
    chk_idle_state("reset_in_point");
    bus.ball_x = 10'd320;
    ticks(60);
    chk("reset_in_point.idle_hold", int'(bus.ball_hold), 1);
    $display("reset_in_point: score=%0d:%0d hold=%0d", bus.p1_score,
             bus.p2_score, bus.ball_hold);

`ifdef GAME_REFEREE_PAUSE_EN
    press_start();
    ticks(30);
    pause = 1'b1;
    ticks(10);
    pause = 1'b0;
    ticks(29);
    chk("pause.serve_frozen", int'(bus.ball_hold), 1);
    ticks(1);
    chk("pause.serve_done", int'(bus.ball_hold), 0);
    pause = 1'b1;
    @(negedge clk);
    chk("pause.play_hold", int'(bus.ball_hold), 1);
    bus.ball_x = 10'd36; bus.ball_y = 9'd100; bus.p1_y = 9'd50;
    ticks(1);
    chk("pause.no_h_col", int'(bus.h_col), 0);
    pause = 1'b0;
    @(negedge clk);
    chk("pause.release_hold", int'(bus.ball_hold), 0);
    $display("pause: hold=%0d", bus.ball_hold);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
